// File: rtl/motor_cmd_scheduler.sv
// Framed position-delta command parser feeding per-motor shadow registers, and
// a frame-tick dispatcher that walks every motor over a shared delta bus.
//
// state  | meaning
// P_IDLE | hunting for the 0x53 start byte
// P_IDX  | expecting motor index
// P_DHI  | expecting delta high byte
// P_DLO  | expecting delta low byte
// P_CSUM | expecting checksum; commit or discard
// D_IDLE | waiting for frame_tick
// D_RUN  | scanning motor scan_s, one per clock
module motor_cmd_scheduler #(
  parameter int NUM_MOTORS   = 12,
  parameter int DELTA_W      = 16,
  parameter int BYTE_TIMEOUT = 2048
) (
  input  logic                  CLK_10MHZ,
  input  logic                  RESET,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  frame_tick,
  output logic [NUM_MOTORS-1:0] load_strobe,
  output logic [DELTA_W-1:0]    delta_bus,
  output logic                  cmd_ack,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  dispatch_busy
);
  localparam int SW = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
  localparam int TW = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam logic [SW-1:0] LAST_S  = SW'(NUM_MOTORS - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(BYTE_TIMEOUT - 1);
  localparam logic [7:0]    NUM_M8  = 8'(NUM_MOTORS);

  typedef enum logic [2:0] {P_IDLE, P_IDX, P_DHI, P_DLO, P_CSUM} p_state_t;
  typedef enum logic {D_IDLE, D_RUN} d_state_t;

  p_state_t              p_state;
  d_state_t              d_state;
  logic [7:0]            idx_q, dhi_q, dlo_q;
  logic [TW-1:0]         to_cnt;
  logic [SW-1:0]         scan_s;
  logic [NUM_MOTORS-1:0] pending;
  logic [DELTA_W-1:0]    shadow [NUM_MOTORS];

  logic                  commit_en, disp_en;
  logic [SW-1:0]         commit_idx, disp_idx;
  logic [NUM_MOTORS-1:0] pend_set, pend_clr;

  always_comb begin
    commit_en  = (p_state == P_CSUM) && rx_valid && (idx_q < NUM_M8) &&
                 (rx_data == (idx_q ^ dhi_q ^ dlo_q));
    commit_idx = idx_q[SW-1:0];
    // Registered outputs lead the scan state: motor 0 is judged on the tick edge itself.
    disp_en    = (d_state == D_IDLE) ? frame_tick : (scan_s != LAST_S);
    disp_idx   = (d_state == D_IDLE) ? '0 : scan_s + 1'b1;
    pend_set   = commit_en ? (NUM_MOTORS'(1) << commit_idx) : '0;
    pend_clr   = disp_en ? (NUM_MOTORS'(1) << disp_idx) : '0;
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (RESET) begin
      p_state   <= P_IDLE;
      idx_q     <= '0;
      dhi_q     <= '0;
      dlo_q     <= '0;
      to_cnt    <= '0;
      cmd_ack   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cmd_ack   <= 1'b0;
      frame_err <= 1'b0;
      if (rx_valid)
        to_cnt <= '0;
      else if (p_state != P_IDLE)
        to_cnt <= to_cnt + 1'b1;
      if (rx_valid) begin
        case (p_state)
          P_IDLE: if (rx_data == 8'h53) p_state <= P_IDX;
          P_IDX: begin
            idx_q   <= rx_data;
            p_state <= P_DHI;
          end
          P_DHI: begin
            dhi_q   <= rx_data;
            p_state <= P_DLO;
          end
          P_DLO: begin
            dlo_q   <= rx_data;
            p_state <= P_CSUM;
          end
          P_CSUM: begin
            p_state <= P_IDLE;
            if (commit_en) cmd_ack <= 1'b1;
            else           frame_err <= 1'b1;
          end
          default: p_state <= P_IDLE;
        endcase
      end else if ((p_state != P_IDLE) && (to_cnt == TO_LAST)) begin
        p_state   <= P_IDLE;
        frame_err <= 1'b1;
        to_cnt    <= '0;
      end
    end
  end

  // A commit landing on the motor being dispatched re-arms it: set wins over clear.
  always_ff @(posedge CLK_10MHZ) begin
    if (RESET) begin
      pending <= '0;
      for (int i = 0; i < NUM_MOTORS; i++) shadow[i] <= '0;
    end else begin
      pending <= (pending & ~pend_clr) | pend_set;
      if (commit_en) shadow[commit_idx] <= DELTA_W'({dhi_q, dlo_q});
    end
  end

  always_ff @(posedge CLK_10MHZ) begin
    if (RESET) begin
      d_state       <= D_IDLE;
      scan_s        <= '0;
      load_strobe   <= '0;
      delta_bus     <= '0;
      overrun       <= 1'b0;
      dispatch_busy <= 1'b0;
    end else begin
      overrun     <= 1'b0;
      load_strobe <= '0;
      delta_bus   <= '0;
      if (disp_en && pending[disp_idx]) begin
        load_strobe <= NUM_MOTORS'(1) << disp_idx;
        delta_bus   <= shadow[disp_idx];
      end
      case (d_state)
        D_IDLE: if (frame_tick) begin
          d_state       <= D_RUN;
          scan_s        <= '0;
          dispatch_busy <= 1'b1;
        end
        D_RUN: begin
          overrun <= frame_tick;
          if (scan_s == LAST_S) begin
            d_state       <= D_IDLE;
            dispatch_busy <= 1'b0;
          end else begin
            scan_s <= scan_s + 1'b1;
          end
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Directed bench for motor_cmd_scheduler: frame table plus hand-built timing sequences.
module tb_motor_cmd_scheduler;
  logic        CLK_10MHZ, RESET, rx_valid, frame_tick;
  logic [7:0]  rx_data;
  logic [11:0] load_strobe;
  logic [15:0] delta_bus;
  logic        cmd_ack, frame_err, overrun, dispatch_busy;

  motor_cmd_scheduler #(.NUM_MOTORS(12), .DELTA_W(16), .BYTE_TIMEOUT(2048)) dut (
    .CLK_10MHZ(CLK_10MHZ), .RESET(RESET), .rx_valid(rx_valid), .rx_data(rx_data),
    .frame_tick(frame_tick), .load_strobe(load_strobe), .delta_bus(delta_bus),
    .cmd_ack(cmd_ack), .frame_err(frame_err), .overrun(overrun),
    .dispatch_busy(dispatch_busy)
  );

  initial begin
    CLK_10MHZ = 1'b0;
    forever #50 CLK_10MHZ = ~CLK_10MHZ;
  end

  typedef struct {
    logic [55:0] bytes;
    int          nb;
    int          exp_ack;
    int          exp_err;
    int          exp_idx;
    logic [15:0] exp_d;
  } vec_t;

  typedef struct {
    int          c;
    logic [11:0] st;
    logic [15:0] d;
  } st_t;

  vec_t vecs [8];
  st_t  st_q [$];
  int   total = 0, bad = 0;
  int   cyc = 0;
  int   n_ack, n_err, n_ov, n_busy, busy_first, busy_last, ack_c, ov_c;
  int   t0, k;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic clear_log();
    n_ack = 0; n_err = 0; n_ov = 0; n_busy = 0;
    busy_first = -1; busy_last = -1; ack_c = -1; ov_c = -1;
    st_q.delete();
  endtask

  // Inputs applied during cycle cyc; observations afterwards belong to cycle cyc+1.
  task automatic clk1(input logic v, input logic [7:0] d, input logic t);
    rx_valid = v; rx_data = d; frame_tick = t;
    @(posedge CLK_10MHZ);
    #1;
    rx_valid = 1'b0; frame_tick = 1'b0;
    cyc++;
    if (cmd_ack)   begin n_ack++; ack_c = cyc; end
    if (frame_err) n_err++;
    if (overrun)   begin n_ov++; ov_c = cyc; end
    if (dispatch_busy) begin
      if (n_busy == 0) busy_first = cyc;
      busy_last = cyc;
      n_busy++;
    end
    if (load_strobe != 12'h000) st_q.push_back('{cyc, load_strobe, delta_bus});
    if (load_strobe == 12'h000) chk("idle_bus_zero", int'(delta_bus), 0);
    else                        chk("strobe_onehot", int'($onehot(load_strobe)), 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk1(1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [55:0] b, input int nb);
    for (int j = 0; j < nb; j++) clk1(1'b1, b[55 - 8*j -: 8], 1'b0);
  endtask

  task automatic tick_scan();
    clear_log();
    t0 = cyc;
    clk1(1'b0, 8'h00, 1'b1);
    idle(14);
  endtask

  initial begin
    vecs[0] = '{56'h5303012C2E0000, 5, 1, 0, 3,  16'h012C};
    vecs[1] = '{56'h53000005050000, 5, 1, 0, 0,  16'h0005};
    vecs[2] = '{56'h530BFFFB0F0000, 5, 1, 0, 11, 16'hFFFB};
    vecs[3] = '{56'h53020010000000, 5, 0, 1, -1, 16'h0000};
    vecs[4] = '{56'h530C00010D0000, 5, 0, 1, -1, 16'h0000};
    vecs[5] = '{56'h41425307123421, 7, 1, 0, 7,  16'h1234};
    vecs[6] = '{56'h530A80008A0000, 5, 1, 0, 10, 16'h8000};
    vecs[7] = '{56'h53055300560000, 5, 1, 0, 5,  16'h5300};

    RESET = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; frame_tick = 1'b0;
    clear_log();
    idle(3);
    chk("rst_strobe", int'(load_strobe), 0);
    chk("rst_delta", int'(delta_bus), 0);
    chk("rst_ack", int'(cmd_ack), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_ovr", int'(overrun), 0);
    chk("rst_busy", int'(dispatch_busy), 0);
    RESET = 1'b0;
    idle(2);

    for (int v = 0; v < 8; v++) begin
      clear_log();
      send(vecs[v].bytes, vecs[v].nb);
      idle(2);
      chk($sformatf("v%0d_ack", v), n_ack, vecs[v].exp_ack);
      chk($sformatf("v%0d_err", v), n_err, vecs[v].exp_err);
      tick_scan();
      chk($sformatf("v%0d_busy_len", v), n_busy, 12);
      chk($sformatf("v%0d_busy_first", v), busy_first, t0 + 1);
      chk($sformatf("v%0d_busy_last", v), busy_last, t0 + 12);
      if (vecs[v].exp_idx >= 0) begin
        chk($sformatf("v%0d_nstrobe", v), st_q.size(), 1);
        if (st_q.size() == 1) begin
          chk($sformatf("v%0d_st_cyc", v), st_q[0].c, t0 + 1 + vecs[v].exp_idx);
          chk($sformatf("v%0d_st_word", v), int'(st_q[0].st), 1 << vecs[v].exp_idx);
          chk($sformatf("v%0d_delta", v), int'(st_q[0].d), int'(vecs[v].exp_d));
        end
      end else begin
        chk($sformatf("v%0d_nstrobe", v), st_q.size(), 0);
      end
    end

    // Two motors pending together; a second tick finds nothing.
    send(56'h53000005050000, 5);
    send(56'h530BFFFB0F0000, 5);
    idle(2);
    tick_scan();
    chk("pair_nstrobe", st_q.size(), 2);
    if (st_q.size() == 2) begin
      chk("pair_c0", st_q[0].c, t0 + 1);
      chk("pair_w0", int'(st_q[0].st), 12'h001);
      chk("pair_d0", int'(st_q[0].d), 16'h0005);
      chk("pair_c1", st_q[1].c, t0 + 12);
      chk("pair_w1", int'(st_q[1].st), 12'h800);
      chk("pair_d1", int'(st_q[1].d), 16'hFFFB);
    end
    tick_scan();
    chk("pair_retick_nstrobe", st_q.size(), 0);

    // Inter-byte timeout after idx, then a clean frame.
    clear_log();
    send(56'h53050000000000, 2);
    k = 0;
    for (int i = 1; i <= 2200; i++) begin
      clk1(1'b0, 8'h00, 1'b0);
      if (n_err != 0) begin
        k = i;
        break;
      end
    end
    chk("timeout_cycles", k, 2048);
    chk("timeout_err", n_err, 1);
    clear_log();
    send(56'h53050007020000, 5);
    idle(2);
    chk("post_to_ack", n_ack, 1);
    chk("post_to_err", n_err, 0);
    tick_scan();
    chk("post_to_nstrobe", st_q.size(), 1);
    if (st_q.size() == 1) begin
      chk("post_to_cyc", st_q[0].c, t0 + 6);
      chk("post_to_delta", int'(st_q[0].d), 16'h0007);
    end

    // Commit to motor 4 on the very edge it is dispatched, plus an overrun tick.
    send(56'h53040001050000, 5);
    idle(2);
    send(56'h53040002000000, 4);
    clear_log();
    t0 = cyc;
    clk1(1'b0, 8'h00, 1'b1);
    idle(3);
    clk1(1'b1, 8'h06, 1'b0);
    idle(1);
    clk1(1'b0, 8'h00, 1'b1);
    idle(10);
    chk("race_nstrobe", st_q.size(), 1);
    if (st_q.size() == 1) begin
      chk("race_cyc", st_q[0].c, t0 + 5);
      chk("race_old_delta", int'(st_q[0].d), 16'h0001);
    end
    chk("race_ack_cyc", ack_c, t0 + 5);
    chk("race_ovr_n", n_ov, 1);
    chk("race_ovr_cyc", ov_c, t0 + 7);
    chk("race_busy_len", n_busy, 12);
    chk("race_busy_last", busy_last, t0 + 12);
    tick_scan();
    chk("race2_nstrobe", st_q.size(), 1);
    if (st_q.size() == 1) begin
      chk("race2_cyc", st_q[0].c, t0 + 5);
      chk("race2_delta", int'(st_q[0].d), 16'h0002);
    end

    // Reset in the middle of a dispatch scan.
    send(56'h53010011100000, 5);
    send(56'h53090099900000, 5);
    idle(2);
    clear_log();
    t0 = cyc;
    clk1(1'b0, 8'h00, 1'b1);
    idle(2);
    RESET = 1'b1;
    idle(1);
    chk("mrst_strobe", int'(load_strobe), 0);
    chk("mrst_delta", int'(delta_bus), 0);
    chk("mrst_busy", int'(dispatch_busy), 0);
    idle(1);
    RESET = 1'b0;
    idle(12);
    chk("mrst_nstrobe", st_q.size(), 1);
    if (st_q.size() == 1) chk("mrst_pre_cyc", st_q[0].c, t0 + 2);
    chk("mrst_busy_last", busy_last, t0 + 3);
    tick_scan();
    chk("mrst_retick_nstrobe", st_q.size(), 0);
    chk("mrst_retick_busy", n_busy, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
